seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples needed to accept a scan slot; legal range is 1..255.
REQ-002 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 an  input  4  is the anode enables, active-low; an[k]=0 selects digit position k.
REQ-005 seg  input  7  is the segment pattern, active-low, ordered {g,f,e,d,c,b,a} (bit6=g, bit0=a).
REQ-006 digit0..digit3  output  4 each  hold the last accepted BCD value for each position.
REQ-007 valid  output  4  valid[k]=1 means digit_k holds a successfully decoded value.
REQ-008 err_pulse  output  1  is a one-cycle pulse when an accepted pattern is not in the decode table.
REQ-009 frame_done  output  1  is a one-cycle pulse when all four positions have been accepted since the previous pulse.

Function
REQ-010 Each cycle the block shall register {an,seg} as the current sample; sample k is "selected" when exactly one an bit is 0.
REQ-011 Non-one-hot-low an (all 1, or more than one 0) shall clear the stability counter and set the armed flag; nothing is captured.
REQ-012 The stability counter is 8-bit and saturating.
  - Selected sample equal to the previous sample: counter increments.
  - Otherwise: counter loads 1 and the armed flag sets.
REQ-013 Acceptance occurs in the cycle the counter reaches STABLE_CYCLES while armed.
  - Armed then clears, so a held pattern is accepted exactly once.
  - The same pattern is re-accepted only after an or seg changes.
REQ-014 Decode table (seg -> value):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
REQ-015 On acceptance with a table hit, digit_k and valid[k]=1 shall update on the next rising edge; latency is STABLE_CYCLES+1 clocks from the first cycle the pair is applied.
REQ-016 On acceptance with a table miss (including blank 1111111):
  - digit_k holds its value and valid[k] clears.
  - err_pulse=1 for exactly one cycle, with the same timing as REQ-015.
REQ-017 A 4-bit seen mask shall set bit k on every acceptance, hit or miss.
  - When the mask becomes 1111, frame_done pulses one cycle, coincident with that acceptance's outputs, and the mask clears.
  - If that same acceptance is also a miss, err_pulse and frame_done assert together.
REQ-018 Accepting a position already in the seen mask shall update its digit/valid but shall not double-count toward frame_done.
REQ-019 Only one position can be accepted per cycle, so no simultaneous-acceptance arbitration is required.
REQ-020 An an change between two one-hot values with seg unchanged is a sample change; the counter restarts per REQ-012.

Reset
REQ-021 While rst_n=0:
  - digit0..3=0, valid=0000, err_pulse=0, frame_done=0
  - sample register = {1111,1111111}, counter=0, armed=1, seen mask=0000
REQ-022 Reset asserted mid-acceptance shall discard the pending acceptance; after release, a slot needs a full STABLE_CYCLES of new samples before acceptance.

Verification
REQ-023 STABLE_CYCLES=4; hold an=1110, seg=0100100 for 10 cycles -> digit0=2, valid[0]=1 exactly 5 clocks after first apply, one acceptance only, err_pulse never asserts.
REQ-024 Hold an=1101 with seg=0110000 for 3 cycles, then seg=0010010 for 4 cycles -> digit1=5 only; the 3 is never captured.
REQ-025 Scan 1110/1101/1011/0111 with 0,1,8,9, each held 4 cycles -> digits=0,1,8,9, valid=1111, one frame_done on the 4th acceptance.
REQ-026 an=1011, seg=1111111 for 4 cycles after valid[2]=1 -> valid[2]=0, digit2 unchanged, one err_pulse.
REQ-027 an=1100 for 20 cycles -> no output change; then an=0111 with seg=1111000 for 4 cycles -> digit3=7.
REQ-028 Deassert rst_n on cycle 3 of a 4-cycle hold -> all outputs 0; after release, acceptance needs 4 fresh cycles.

Source files
------------

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_if
//  Description : Bundle between a multiplexed 7-segment scan source and the
//                seg_scan_decoder. The master drives the anode enables and
//                segment pattern. The slave returns decoded digits and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_if;
  logic [3:0] an;          // anode enables, active-low
  logic [6:0] seg;         // {g,f,e,d,c,b,a}, active-low
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] valid;
  logic       err_pulse;
  logic       frame_done;

  modport master (
    output an, seg,
    input  digit0, digit1, digit2, digit3, valid, err_pulse, frame_done
  );

  modport slave (
    input  an, seg,
    output digit0, digit1, digit2, digit3, valid, err_pulse, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Recovers four BCD digits from a scanned, multiplexed 7-segment
//                display. Each anode slot must be stable for STABLE_CYCLES
//                samples before it is accepted and decoded. Unknown patterns
//                raise err_pulse. frame_done pulses once all four positions
//                have been seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4    // legal range 1..255
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam logic [7:0]  c_stable      = 8'(STABLE_CYCLES);
  localparam logic [10:0] c_sample_idle = 11'h7FF;
  localparam logic [7:0]  c_count_max   = 8'hFF;

  // Registered state
  logic [10:0] r_sample;        // {an, seg} seen on the previous edge
  logic [7:0]  r_count;         // saturating stability counter
  logic        r_armed;         // slot may still be accepted
  logic [3:0]  r_seen;          // positions accepted in the current frame
  logic        r_err_pulse;
  logic        r_frame_done;

  // Combinational helpers
  logic [10:0] w_in;
  logic        w_in_sel;
  logic        w_in_same;
  logic [3:0]  w_pos;
  logic        w_accept;
  logic        w_hit;
  logic [3:0]  w_value;
  logic [3:0]  w_seen_next;
  logic        w_frame_full;
  logic [3:0]  w_digit [4];
  logic [3:0]  w_valid;

  assign w_in      = {bus.an, bus.seg};
  assign w_in_sel  = $onehot(~bus.an);
  assign w_in_same = (w_in == r_sample);

  // Position of the registered sample, active-high one-hot
  assign w_pos    = ~r_sample[10:7];
  // Counter value is produced by the edge that saw the sample, so the
  // decision is made here and the outputs follow on the next edge.
  assign w_accept = r_armed && (r_count == c_stable) && $onehot(w_pos);

  assign w_seen_next  = r_seen | w_pos;
  assign w_frame_full = (w_seen_next == 4'hF);

  // Sample register, stability counter and one-shot arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= c_sample_idle;
      r_count  <= 8'd0;
      r_armed  <= 1'b1;
    end else begin
      r_sample <= w_in;
      if (!w_in_sel) begin
        r_count <= 8'd0;
        r_armed <= 1'b1;
      end else if (!w_in_same) begin
        r_count <= 8'd1;
        r_armed <= 1'b1;
      end else begin
        if (r_count != c_count_max) begin
          r_count <= r_count + 8'd1;
        end
        if (w_accept) begin
          r_armed <= 1'b0;
        end
      end
    end
  end

  // Segment pattern to BCD lookup; anything else is a miss
  always_comb begin
    w_hit   = 1'b1;
    w_value = 4'd0;
    case (r_sample[6:0])
      7'b1000000: w_value = 4'd0;
      7'b1111001: w_value = 4'd1;
      7'b0100100: w_value = 4'd2;
      7'b0110000: w_value = 4'd3;
      7'b0011001: w_value = 4'd4;
      7'b0010010: w_value = 4'd5;
      7'b0000010: w_value = 4'd6;
      7'b1111000: w_value = 4'd7;
      7'b0000000: w_value = 4'd8;
      7'b0010000: w_value = 4'd9;
      default:    w_hit   = 1'b0;
    endcase
  end

  // Error/frame pulses and the per-frame seen mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen       <= 4'h0;
      r_err_pulse  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_err_pulse  <= w_accept && !w_hit;
      r_frame_done <= w_accept && w_frame_full;
      if (w_accept) begin
        r_seen <= w_frame_full ? 4'h0 : w_seen_next;
      end
    end
  end

  generate
    for (genvar k = 0; k < 4; k++) begin : g_pos
      logic [3:0] r_digit;
      logic       r_valid;

      // Capture a decoded value for this position; a miss keeps the old digit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_digit <= 4'd0;
          r_valid <= 1'b0;
        end else if (w_accept && w_pos[k]) begin
          if (w_hit) begin
            r_digit <= w_value;
          end
          r_valid <= w_hit;
        end
      end

      assign w_digit[k] = r_digit;
      assign w_valid[k] = r_valid;
    end
  endgenerate

  assign bus.digit0     = w_digit[0];
  assign bus.digit1     = w_digit[1];
  assign bus.digit2     = w_digit[2];
  assign bus.digit3     = w_digit[3];
  assign bus.valid      = w_valid;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_decoder
//  Description : Scoreboard bench for seg_scan_decoder. Each stimulus hold that
//                should produce an acceptance pushes the expected output state
//                and due cycle. A monitor pops one entry per observed output
//                event and compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

  localparam int STABLE = 4;

  typedef struct {
    int          due;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        err;
    logic        frame;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [3:0] m_dig [4];
  logic [3:0] m_val;
  logic [15:0] cur_dig;
  logic [15:0] prev_dig = 16'h0;
  logic [3:0]  prev_val = 4'h0;

  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_tab [4] = '{7'b1000000, 7'b1111001, 7'b0000000, 7'b0010000};
  logic [3:0] val_tab [4] = '{4'd0, 4'd1, 4'd8, 4'd9};

  seg_scan_if bus ();

  seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign cur_dig = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hold(4'b1111, 7'b1111111, n);
  endtask

  task automatic push_ev(input int due, input int pos, input bit hit,
                         input logic [3:0] value, input bit frame);
    ev_t e;
    if (hit) m_dig[pos] = value;
    m_val[pos] = hit;
    e.due    = due;
    e.digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    e.valid  = m_val;
    e.err    = !hit;
    e.frame  = frame;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_digit0"}, 32'(bus.digit0), 0);
    check({pfx, "_digit1"}, 32'(bus.digit1), 0);
    check({pfx, "_digit2"}, 32'(bus.digit2), 0);
    check({pfx, "_digit3"}, 32'(bus.digit3), 0);
    check({pfx, "_valid"},  32'(bus.valid), 0);
    check({pfx, "_err"},    32'(bus.err_pulse), 0);
    check({pfx, "_frame"},  32'(bus.frame_done), 0);
  endtask

  // Any visible output activity is one event and must match the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 &&
        (cur_dig !== prev_dig || bus.valid !== prev_val ||
         bus.err_pulse !== 1'b0 || bus.frame_done !== 1'b0)) begin
      check("ev_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ev_cycle",  32'(cyc), 32'(mon_e.due));
        check("ev_digits", 32'(cur_dig), 32'(mon_e.digits));
        check("ev_valid",  32'(bus.valid), 32'(mon_e.valid));
        check("ev_err",    32'(bus.err_pulse), 32'(mon_e.err));
        check("ev_frame",  32'(bus.frame_done), 32'(mon_e.frame));
      end
    end
    prev_dig = cur_dig;
    prev_val = bus.valid;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_val   = 4'h0;
    rst_n   = 1'b0;
    bus.an  = 4'b1111;
    bus.seg = 7'b1111111;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    idle(3);

    // Single stable slot held long: one acceptance, 5 clocks after apply
    push_ev(cyc + STABLE + 1, 0, 1'b1, 4'd2, 1'b0);
    hold(4'b1110, 7'b0100100, 10);
    idle(2);

    // Too-short hold of 3 never captured; following 5 is
    hold(4'b1101, 7'b0110000, 3);
    push_ev(cyc + STABLE + 1, 1, 1'b1, 4'd5, 1'b0);
    hold(4'b1101, 7'b0010010, 4);
    idle(3);

    // Full scan back-to-back; frame_done on the fourth acceptance only
    for (int i = 0; i < 4; i++) begin
      push_ev(cyc + STABLE + 1, i, 1'b1, val_tab[i], i == 3);
      hold(an_tab[i], seg_tab[i], 4);
    end
    idle(3);

    // Blank pattern on a valid position: miss, digit kept
    push_ev(cyc + STABLE + 1, 2, 1'b0, 4'd0, 1'b0);
    hold(4'b1011, 7'b1111111, 4);
    idle(3);

    // Two anodes low: ignored; then a clean slot for position 3
    hold(4'b1100, 7'b1111000, 20);
    push_ev(cyc + STABLE + 1, 3, 1'b1, 4'd7, 1'b0);
    hold(4'b0111, 7'b1111000, 4);
    idle(3);

    // Miss that also completes the frame: err_pulse and frame_done together
    push_ev(cyc + STABLE + 1, 0, 1'b1, 4'd4, 1'b0);
    hold(4'b1110, 7'b0011001, 4);
    push_ev(cyc + STABLE + 1, 1, 1'b0, 4'd0, 1'b1);
    hold(4'b1101, 7'b1111111, 4);
    idle(3);
    drain(20);

    // Reset in the third cycle of a hold; needs a fresh full hold afterwards
    hold(4'b1110, 7'b0000010, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_val = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = cyc;
    push_ev(start + STABLE + 1, 0, 1'b1, 4'd6, 1'b0);
    hold(4'b1110, 7'b0000010, 8);
    idle(3);
    drain(20);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
